cube_result_collector: RTL and testbench

- Sits directly downstream of the cube solver/checker.
- Consumes each accepted 12-bit edge-set word (connected, 3D-valid, canonical) over a valid/ready stream and buffers it in a FIFO for host/UART drain.
- Keeps a histogram of accepted cubes by edge count (popcount 0..12) plus a running total, for comparison against the known per-edge-count enumeration.

---
 rtl/cube_result_collector.sv | 127 ++++++++++++
 tb/tb_cube_result_collector.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/cube_result_collector.sv
// Buffers accepted cube edge-set words in a FIFO and histograms them by edge count (0..12) plus a total.
// Latency: push-to-out_valid 1 cycle (no bypass); hist_data 1 cycle after hist_sel. Optional macro CUBE_COLLECTOR_SAT_EN.
// Backpressure: in_ready low when full or during clr; no same-cycle refill of a full FIFO.
module cube_result_collector #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [11:0]              in_cube,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [11:0]              out_cube,
    output logic [3:0]               out_popcnt,
    input  logic [3:0]               hist_sel,
    output logic [CNT_W-1:0]         hist_data,
    output logic [CNT_W-1:0]         total,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     hist_ovf
);

    localparam int AW    = $clog2(DEPTH);
    localparam int NBINS = 13;
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    function automatic logic [3:0] popcnt12(input logic [11:0] v);
        logic [3:0] s;
        s = 4'd0;
        for (int i = 0; i < 12; i++) s = s + 4'(v[i]);
        return s;
    endfunction

    logic [11:0]      r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic [CNT_W-1:0] r_bin [NBINS];
    logic [CNT_W-1:0] r_total;
    logic [CNT_W-1:0] r_hist_data;
    logic [CNT_W-1:0] w_hist_mux;
    logic [3:0]       w_in_pc;
    logic             w_push;
    logic             w_pop;

    assign in_ready   = (r_level != FULL_LVL) && !clr;
    assign out_valid  = (r_level != '0);
    assign w_push     = in_valid && in_ready;
    assign w_pop      = out_valid && out_ready;
    assign w_in_pc    = popcnt12(in_cube);
    // Head is masked while empty so out_cube reads 0 after reset without resetting the array.
    assign out_cube   = out_valid ? r_mem[r_rd_ptr] : 12'h000;
    assign out_popcnt = popcnt12(out_cube);
    assign fifo_level = r_level;
    assign total      = r_total;
    assign hist_data  = r_hist_data;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= in_cube;
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

`ifdef CUBE_COLLECTOR_SAT_EN
    logic r_ovf;
    assign hist_ovf = r_ovf;
`else
    assign hist_ovf = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int b = 0; b < NBINS; b++) r_bin[b] <= '0;
            r_total <= '0;
`ifdef CUBE_COLLECTOR_SAT_EN
            r_ovf   <= 1'b0;
`endif
        end else if (w_push) begin
            for (int b = 0; b < NBINS; b++) begin
                if (w_in_pc == 4'(b)) begin
`ifdef CUBE_COLLECTOR_SAT_EN
                    if (r_bin[b] == '1) r_ovf <= 1'b1;
                    else                r_bin[b] <= r_bin[b] + 1'b1;
`else
                    r_bin[b] <= r_bin[b] + 1'b1;
`endif
                end
            end
`ifdef CUBE_COLLECTOR_SAT_EN
            if (r_total == '1) r_ovf <= 1'b1;
            else               r_total <= r_total + 1'b1;
`else
            r_total <= r_total + 1'b1;
`endif
        end
    end

    // Selects 13..15 fall through to 0.
    always_comb begin
        w_hist_mux = '0;
        for (int b = 0; b < NBINS; b++) begin
            if (hist_sel == 4'(b)) w_hist_mux = r_bin[b];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_hist_data <= '0;
        else     r_hist_data <= w_hist_mux;
    end

endmodule

// File: tb/tb_cube_result_collector.sv
// Directed bench for cube_result_collector: main instance (DEPTH 16, CNT_W 12) and a CNT_W 4 instance for counter limits.
module tb_cube_result_collector;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] in_cube = 12'h000;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [11:0] out_cube;
    logic [3:0]  out_popcnt;
    logic [3:0]  hist_sel = 4'd0;
    logic [11:0] hist_data;
    logic [11:0] total;
    logic [4:0]  fifo_level;
    logic        hist_ovf;

    logic        s_in_valid = 1'b0;
    logic        s_in_ready;
    logic [11:0] s_in_cube = 12'h000;
    logic        s_out_valid;
    logic        s_out_ready = 1'b1;
    logic [11:0] s_out_cube;
    logic [3:0]  s_out_popcnt;
    logic [3:0]  s_hist_sel = 4'd4;
    logic [3:0]  s_hist_data;
    logic [3:0]  s_total;
    logic [4:0]  s_fifo_level;
    logic        s_hist_ovf;

    int n_cmp = 0;
    int n_err = 0;
    int tot_exp = 0;

    always #5 clk = ~clk;

    cube_result_collector #(.DEPTH(16), .CNT_W(12)) u_dut (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_cube(in_cube),
        .out_valid(out_valid), .out_ready(out_ready), .out_cube(out_cube), .out_popcnt(out_popcnt),
        .hist_sel(hist_sel), .hist_data(hist_data), .total(total),
        .fifo_level(fifo_level), .hist_ovf(hist_ovf)
    );

    cube_result_collector #(.DEPTH(16), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .clr(1'b0),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_cube(s_in_cube),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_cube(s_out_cube), .out_popcnt(s_out_popcnt),
        .hist_sel(s_hist_sel), .hist_data(s_hist_data), .total(s_total),
        .fifo_level(s_fifo_level), .hist_ovf(s_hist_ovf)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [11:0] v);
        in_valid = 1'b1;
        in_cube  = v;
        step();
        in_valid = 1'b0;
        tot_exp++;
    endtask

    task automatic pop_expect(input string tag, input logic [11:0] v);
        check_val({tag, "_vld"}, 32'(out_valid), 32'd1);
        check_val({tag, "_dat"}, 32'(out_cube), 32'(v));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rx_cnt;
        int max_lvl;

        step();
        step();
        rst = 1'b0;
        step();
        check_val("rst_level",  32'(fifo_level), 32'd0);
        check_val("rst_oval",   32'(out_valid),  32'd0);
        check_val("rst_ocube",  32'(out_cube),   32'd0);
        check_val("rst_opc",    32'(out_popcnt), 32'd0);
        check_val("rst_total",  32'(total),      32'd0);
        check_val("rst_hist",   32'(hist_data),  32'd0);
        check_val("rst_ovf",    32'(hist_ovf),   32'd0);
        check_val("rst_irdy",   32'(in_ready),   32'd1);

        // Three pushes, downstream stalled; popcounts 3, 6, 6.
        push(12'h007);
        push(12'h0F3);
        push(12'h5A5);
        check_val("t1_level", 32'(fifo_level), 32'd3);
        check_val("t1_total", 32'(total),      32'd3);
        check_val("t1_ocube", 32'(out_cube),   32'h007);
        check_val("t1_opc",   32'(out_popcnt), 32'd3);
        hist_sel = 4'd3;  step(); check_val("t1_bin3",  32'(hist_data), 32'd1);
        hist_sel = 4'd6;  step(); check_val("t1_bin6",  32'(hist_data), 32'd2);
        hist_sel = 4'd4;  step(); check_val("t1_bin4",  32'(hist_data), 32'd0);
        hist_sel = 4'd13; step(); check_val("t1_sel13", 32'(hist_data), 32'd0);
        check_val("t1_hold", 32'(out_cube), 32'h007);
        pop_expect("t1_p0", 12'h007);
        pop_expect("t1_p1", 12'h0F3);
        check_val("t1_p2_pc", 32'(out_popcnt), 32'd6);
        pop_expect("t1_p2", 12'h5A5);
        check_val("t1_empty", 32'(out_valid), 32'd0);

        // Fill to DEPTH starting at pointer 3 so the drain crosses the wrap.
        for (int i = 1; i <= 15; i++) push(12'h100 + 12'(i));
        check_val("t2_rdy15", 32'(in_ready), 32'd1);
        push(12'h110);
        check_val("t2_rdy16", 32'(in_ready),   32'd0);
        check_val("t2_full",  32'(fifo_level), 32'd16);
        out_ready = 1'b1;
        #1;
        check_val("t2_norefill", 32'(in_ready), 32'd0);
        check_val("t2_d0", 32'(out_cube), 32'h101);
        step();
        out_ready = 1'b0;
        check_val("t2_rdyback", 32'(in_ready),   32'd1);
        check_val("t2_lvl15",   32'(fifo_level), 32'd15);
        for (int i = 2; i <= 16; i++) pop_expect("t2_drain", 12'h100 + 12'(i));
        check_val("t2_total", 32'(total), 32'(tot_exp));

        // Single push into empty FIFO, downstream ready.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_cube   = 12'hFFE;
        #1;
        check_val("t3_pre_vld", 32'(out_valid), 32'd0);
        step();
        in_valid = 1'b0;
        tot_exp++;
        check_val("t3_vld",   32'(out_valid),  32'd1);
        check_val("t3_ocube", 32'(out_cube),   32'hFFE);
        check_val("t3_opc",   32'(out_popcnt), 32'd11);
        step();
        check_val("t3_lvl", 32'(fifo_level), 32'd0);
        check_val("t3_vld0", 32'(out_valid), 32'd0);

        // Streaming: 40 words through with both sides always ready.
        rx_cnt  = 0;
        max_lvl = 0;
        for (int i = 0; i <= 40; i++) begin
            in_valid = (i < 40);
            in_cube  = 12'(i);
            if (out_valid) begin
                check_val("t4_order", 32'(out_cube), 32'(rx_cnt));
                rx_cnt++;
            end
            step();
            if (i < 40) tot_exp++;
            if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_val("t4_rx",    32'(rx_cnt),  32'd40);
        check_val("t4_maxl",  32'(max_lvl), 32'd1);
        check_val("t4_total", 32'(total),   32'(tot_exp));

        // clr with 5 buffered words and upstream valid.
        for (int i = 1; i <= 5; i++) push(12'(i));
        check_val("t5_lvl5", 32'(fifo_level), 32'd5);
        clr       = 1'b1;
        in_valid  = 1'b1;
        in_cube   = 12'hAAA;
        out_ready = 1'b1;
        #1;
        check_val("t5_irdy", 32'(in_ready), 32'd0);
        step();
        clr       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tot_exp   = 0;
        check_val("t5_lvl",   32'(fifo_level), 32'd0);
        check_val("t5_vld",   32'(out_valid),  32'd0);
        check_val("t5_total", 32'(total),      32'd0);
        for (int b = 0; b <= 12; b++) begin
            hist_sel = 4'(b);
            step();
            check_val("t5_bin", 32'(hist_data), 32'd0);
        end
        push(12'h0C3);
        check_val("t5_post_tot", 32'(total),    32'd1);
        check_val("t5_post_dat", 32'(out_cube), 32'h0C3);

        // Narrow counters: 17 pushes of a popcount-4 word.
        check_val("t6_rst_ovf", 32'(s_hist_ovf), 32'd0);
        s_in_valid = 1'b1;
        s_in_cube  = 12'h00F;
        for (int i = 0; i < 17; i++) step();
        s_in_valid = 1'b0;
        step();
`ifdef CUBE_COLLECTOR_SAT_EN
        check_val("t6_bin4",  32'(s_hist_data), 32'd15);
        check_val("t6_total", 32'(s_total),     32'd15);
        check_val("t6_ovf",   32'(s_hist_ovf),  32'd1);
`else
        check_val("t6_bin4",  32'(s_hist_data), 32'd1);
        check_val("t6_total", 32'(s_total),     32'd1);
        check_val("t6_ovf",   32'(s_hist_ovf),  32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
